move_scheduler: RTL

- Sequences and arbitrates movement requests into the Ball datapath.
- Merges pushbutton requests with accelerometer tilt into one-cycle move pulses per direction.
- Button moves use a fixed rate; tilt moves use a rate proportional to tilt magnitude.
- Sits between debounce/AccelerometerCtl and Ball's movement input, and freezes motion on gameover.

---
 rtl/move_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - merges button/tilt requests into arbitrated one-cycle move pulses.
// Optional move counter is enabled by defining MOVE_STATS_EN.
module move_scheduler #(
  parameter int PRESCALE   = 100000,
  parameter int BTN_PERIOD = 11,
  parameter int MIN_PERIOD = 8,
  parameter int DEADZONE   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        gameover,
  input  logic        restart,
  input  logic        btn_right,
  input  logic        btn_left,
  input  logic        btn_down,
  input  logic        btn_up,
  input  logic [8:0]  accel_x,
  input  logic [8:0]  accel_y,
  output logic [3:0]  move_pulses,
  output logic [1:0]  sched_state,
  output logic [15:0] move_count
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  typedef struct packed {
    logic       active;
    logic       dir;
    logic [7:0] period;
  } axis_sel_t;

  // dir=1 means the positive direction of the axis (right for X, up for Y)
  function automatic axis_sel_t sel_axis(input logic b_pos, input logic b_neg,
                                         input logic [8:0] accel);
    axis_sel_t s;
    s = '0;
    if (b_pos ^ b_neg) begin
      s.active = 1'b1;
      s.dir    = b_pos;
      s.period = 8'(BTN_PERIOD);
    end else if (!b_pos && !b_neg && accel[7:0] >= 8'(DEADZONE)) begin
      s.active = 1'b1;
      s.dir    = accel[8];
      s.period = 8'(MIN_PERIOD) + ((8'd255 - accel[7:0]) >> 3);
    end
    return s;
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            base_tick_q, base_tick_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      pend_dir_q, pend_dir_d;
  logic            rr_q, rr_d;
  logic [3:0]      pulses_q, pulses_d;
  axis_sel_t [1:0] sel;
  logic [1:0]      grant;
  logic            chg;

  assign sel[0] = sel_axis(btn_right, btn_left, accel_x);
  assign sel[1] = sel_axis(btn_up, btn_down, accel_y);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (gameover) state_d = HALT;
               else if (!enable) state_d = IDLE;
      HALT:    if (restart && !gameover) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    chg = (state_d != state_q);

    presc_d     = '0;
    base_tick_d = 1'b0;
    if (state_q == RUN && !chg) begin
      if (presc_q == PW'(PRESCALE - 1)) base_tick_d = 1'b1;
      else presc_d = presc_q + PW'(1);
    end

    grant = '0;
    rr_d  = rr_q;
    if (state_q == RUN && !chg) begin
      if (&pend_q) begin
        grant[rr_q] = 1'b1;
        rr_d        = ~rr_q;
      end else begin
        grant = pend_q;
      end
    end

    pulses_d = '0;
    if (grant[0]) pulses_d = pend_dir_q[0] ? 4'b1000 : 4'b0100;
    if (grant[1]) pulses_d = pend_dir_q[1] ? 4'b0001 : 4'b0010;

    for (int a = 0; a < 2; a++) begin
      cnt_d[a]      = cnt_q[a];
      dir_d[a]      = sel[a].dir;
      pend_d[a]     = pend_q[a];
      pend_dir_d[a] = pend_dir_q[a];
      if (grant[a] || !sel[a].active) pend_d[a] = 1'b0;
      if (!sel[a].active || sel[a].dir != dir_q[a]) begin
        cnt_d[a] = '0;
      end else if (base_tick_q) begin
        // >= lets a period shortened mid-count fire on the very next tick
        if (cnt_q[a] >= sel[a].period - 8'd1) begin
          cnt_d[a]      = '0;
          pend_d[a]     = 1'b1;
          pend_dir_d[a] = sel[a].dir;
        end else begin
          cnt_d[a] = cnt_q[a] + 8'd1;
        end
      end
    end

    if (chg) begin
      cnt_d    = '0;
      pend_d   = '0;
      pulses_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      base_tick_q <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= '0;
      pend_q      <= '0;
      pend_dir_q  <= '0;
      rr_q        <= 1'b0;
      pulses_q    <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      base_tick_q <= base_tick_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      pend_dir_q  <= pend_dir_d;
      rr_q        <= rr_d;
      pulses_q    <= pulses_d;
    end
  end

  assign move_pulses = pulses_q;
  assign sched_state = state_q;

`ifdef MOVE_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 16'(|pulses_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end

  assign move_count = count_q;
`else
  assign move_count = 16'h0000;
`endif

endmodule
